fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer directly upstream of the PC register in the mono-cycle MIPS datapath.
- Drives `next_PC` into the PC register each cycle, reads back the registered `PC`, and issues one instruction-memory read per fetch.
- Presents the returned word to decode with a valid/ready handshake.
- Holds the PC (`next_PC = PC`) while memory or decode stalls, and applies branch/jump redirects, discarding stale in-flight responses.

## Interface
Parameters:
- `MAX_WAIT`, default 16: cycles allowed in WAIT/DRAIN before a fetch error. Legal range 1..255.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `PC` in 32: current PC from the PC register.
- `next_PC` out 32: value the PC register loads at the next edge.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_target` in 32: redirect address. Bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: one-cycle read request pulse.
- `imem_addr` out 32: read address, valid while `imem_req`.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: read data.
- `instr_valid` out 1: instruction available to decode.
- `instr` out 32: instruction word.
- `instr_pc` out 32: address `instr` was fetched from.
- `instr_ready` in 1: decode accepts.
- `fetch_err` out 1: sticky watchdog error.

## Operation
States:
- **IDLE**: no request outstanding. Always goes to REQ next cycle.
- **REQ**: `imem_req=1`, `imem_addr=PC`. Goes to WAIT next cycle.
- **WAIT**: awaiting `imem_rvalid`. On rvalid: `instr<=imem_rdata`, `instr_pc<=` latched request address, go to HOLD.
- **HOLD**: `instr_valid=1`; `instr`/`instr_pc` stable. On `instr_valid && instr_ready` (accept): go to REQ.
- **DRAIN**: awaiting and discarding a stale response. On rvalid: go to REQ; data is dropped.
- **ERR**: terminal until reset. `imem_req=0`, `instr_valid=0`, `next_PC=PC`.

`next_PC` priority:
1. `reset`: 0.
2. State ERR: `PC`.
3. `redirect_valid`: `{redirect_target[31:2],2'b00}`.
4. Accept: `PC+4`, modulo 2^32 (0xFFFFFFFC → 0x00000000).
5. Otherwise: `PC` (hold).

Redirect transitions (`redirect_valid` is ignored in ERR):
- IDLE → REQ.
- REQ → DRAIN (the request is already issued).
- WAIT without rvalid → DRAIN.
- WAIT with rvalid in the same cycle → REQ; the data is discarded.
- DRAIN → DRAIN; with rvalid in the same cycle → REQ.
- HOLD → REQ. If an accept happens in the same cycle, that instruction counts as delivered (it is the branch itself). Otherwise it is dropped and `instr_valid` falls next cycle.

Other rules:
- `imem_rvalid` is sampled only in WAIT/DRAIN and ignored elsewhere.
- At most one request is outstanding.
- Watchdog: an 8-bit counter clears on entry to WAIT/DRAIN and increments each cycle in WAIT/DRAIN without rvalid. When it reaches `MAX_WAIT`: `fetch_err<=1`, state → ERR.

## Timing
- Reset values: state IDLE, `next_PC=0`, `imem_req=0`, `imem_addr=0`, `instr_valid=0`, `instr=0`, `instr_pc=0`, `fetch_err=0`, counter 0.
- Reset asserted mid-operation aborts at the next edge. A later rvalid is ignored because the block is in IDLE/REQ.
- First request occurs in the cycle after reset deasserts: IDLE 1 cycle, then REQ.
- Memory latency L ≥ 1: a request at cycle t can see rvalid earliest at t+1. `instr_valid` rises at t+L+1.
- Accept at cycle c: PC becomes PC+4 at edge c, and the next request issues in cycle c+1 using the new PC.
- Steady-state throughput is one instruction per L+2 cycles with `instr_ready` held high.
- All outputs are registered except `next_PC`, which is combinational from `PC`, state, redirect and handshake.

## Structure
- `fetch_pkg` holds:
  - the `fetch_state_t` enum (IDLE, REQ, WAIT, DRAIN, HOLD, ERR);
  - `INSTR_BYTES = 4`;
  - `PC_RESET = 32'h0`.
- One sub-module, `fetch_watchdog`, holds the counter plus the sticky error flag. Its inputs are `clk`, `reset`, `clear`, `count` and `limit`; its output is `expired`.

## Test plan
- **Reset/start-up:** reset high 3 cycles, then low, L=2, `instr_ready=1`, memory returns addr^32'hA5A5A5A5. Expect requests at 0x0, 0x4, 0x8 spaced 4 cycles apart, and `instr_pc` sequence 0x0, 0x4, 0x8.
- **Decode stall:** hold `instr_ready=0` for 5 cycles in HOLD. Expect `instr`/`instr_pc` stable, `next_PC==PC`, no `imem_req`. Then ready=1 → `next_PC=PC+4` that cycle.
- **Redirect in WAIT:** redirect to 0x00000403 while waiting, response arrives 2 cycles later. Expect the response discarded, `instr_valid` stays 0, and the next `imem_addr` is 0x00000400.
- **Redirect with accept:** redirect to 0x100 in the same cycle as accept at PC 0x20. Expect 0x20 delivered once, `next_PC=0x100`, and the next delivered `instr_pc` is 0x100.
- **Wrap:** PC=0xFFFFFFFC accepted. Expect `next_PC=0x00000000`.
- **Watchdog:** `MAX_WAIT=4`, no rvalid. Expect `fetch_err=1` four cycles after entering WAIT, `next_PC==PC` thereafter, a late rvalid ignored, and reset clearing the error.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned WDOG_W      = 8;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD,
    ERR
  } fetch_state_t;

  // Instruction payload handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } instr_pkt_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response and decode handshake bundle.
interface fetch_sequencer_if import fetch_pkg::*; ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Wait-cycle counter with a sticky expiry flag.
module fetch_watchdog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Count stalled cycles; flag sets on the edge the count reaches the limit.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && !err_q) begin
      cnt_d = cnt_q + WIDTH'(1);
      if (cnt_d == limit) err_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign expired = err_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives next_PC, issues imem reads, hands words to decode.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   PC,
  output logic [XLEN-1:0]   next_PC,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  fetch_sequencer_if.master bus,
  output logic              fetch_err
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(MAX_WAIT);

  fetch_state_t    state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic            instr_valid_q, instr_valid_d;
  instr_pkt_t      pkt_q, pkt_d;

  logic halted;
  logic accept;
  logic waiting;
  logic wd_clear;
  logic wd_count;

  // The watchdog flag takes effect the same cycle it rises, ahead of state ERR.
  assign halted  = (state_q == ERR) || fetch_err;
  assign accept  = instr_valid_q && bus.instr_ready;
  assign waiting = (state_q == WAIT) || (state_q == DRAIN);

  // Next PC: reset, halt, redirect, sequential advance on accept, else hold.
  always_comb begin
    next_PC = PC;
    if (reset) begin
      next_PC = PC_RESET;
    end else if (halted) begin
      next_PC = PC;
    end else if (redirect_valid) begin
      next_PC = align_word(redirect_target);
    end else if (accept) begin
      next_PC = PC + XLEN'(INSTR_BYTES);
    end
  end

  // Next state, registered-output values and watchdog controls.
  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    pkt_d       = pkt_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ:   state_d = redirect_valid ? DRAIN : WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (redirect_valid) begin
            state_d = REQ;
          end else begin
            state_d = HOLD;
            pkt_d   = '{pc: imem_addr_q, instr: bus.imem_rdata};
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (bus.imem_rvalid) state_d = REQ;
      HOLD:  if (accept || redirect_valid) state_d = REQ;
      ERR:   state_d = ERR;
      default: state_d = ERR;
    endcase
    if (fetch_err) state_d = ERR;
    // The PC register holds next_PC during the request cycle.
    if (state_d == REQ) imem_addr_d = next_PC;
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);
    wd_clear      = (state_d != state_q) && ((state_d == WAIT) || (state_d == DRAIN));
    wd_count      = waiting && !bus.imem_rvalid && !fetch_err;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= PC_RESET;
      instr_valid_q <= 1'b0;
      pkt_q         <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      pkt_q         <= pkt_d;
    end
  end

  fetch_watchdog #(.WIDTH(WDOG_W)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .count   (wd_count),
    .limit   (LIMIT),
    .expired (fetch_err)
  );

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = pkt_q.instr;
  assign bus.instr_pc    = pkt_q.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a program-order reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC = '0;
  logic [31:0] next_PC;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_err;

  fetch_sequencer_if bus_if ();

  fetch_sequencer #(.MAX_WAIT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .PC              (PC),
    .next_PC         (next_PC),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus_if),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  // PC register of the surrounding datapath.
  always @(posedge clk) PC <= next_PC;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model controls.
  int  mem_lat   = 2;   // 0 selects a random latency of 1..4
  bit  mem_mute  = 1'b0;
  bit  mem_force = 1'b0;
  bit  spur_en   = 1'b0;
  bit  exp_err   = 1'b0;

  typedef struct {
    int          c;
    logic [31:0] a;
  } req_rec_t;
  req_rec_t req_log[$];

  // Instruction memory: one response per request after the chosen latency.
  initial begin
    bit          pend = 1'b0;
    int          rem = 0;
    logic [31:0] p_addr = '0;
    bus_if.imem_rvalid = 1'b0;
    bus_if.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_if.imem_rvalid = 1'b0;
      bus_if.imem_rdata  = $urandom();
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          rem--;
          if (rem == 0) begin
            pend = 1'b0;
            if (!mem_mute) begin
              bus_if.imem_rvalid = 1'b1;
              bus_if.imem_rdata  = p_addr ^ KEY;
            end
          end
        end else if (spur_en && bus_if.instr_valid && $urandom_range(0, 9) == 0) begin
          bus_if.imem_rvalid = 1'b1;
        end
        if (bus_if.imem_req) begin
          check32("single_outstanding", 32'(pend), 32'd0);
          pend   = 1'b1;
          rem    = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
          p_addr = bus_if.imem_addr;
          req_log.push_back('{c: cyc, a: bus_if.imem_addr});
        end
        if (mem_force) bus_if.imem_rvalid = 1'b1;
      end
    end
  end

  // Monitor: program-order scoreboard plus next_PC and error-flag checks.
  logic [31:0] exp_q[$];
  initial begin : monitor
    logic [31:0] e;
    logic [31:0] exp_npc;
    logic [31:0] tgt;
    bit          acc;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_q.push_back(32'h0);
        check32("next_PC_reset", next_PC, 32'h0);
      end else begin
        acc     = bus_if.instr_valid && bus_if.instr_ready;
        exp_npc = PC;
        if (exp_err) begin
          check32("err_instr_valid", 32'(bus_if.instr_valid), 32'd0);
          check32("err_imem_req", 32'(bus_if.imem_req), 32'd0);
        end else begin
          if (bus_if.imem_req && exp_q.size() > 0)
            check32("imem_addr", bus_if.imem_addr, exp_q[0]);
          if (acc) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL deliver: unexpected instr_pc %h (cycle %0d)", bus_if.instr_pc, cyc);
            end else begin
              e = exp_q.pop_front();
              check32("deliver_pc", bus_if.instr_pc, e);
              check32("deliver_instr", bus_if.instr, e ^ KEY);
              if (!redirect_valid) exp_q.push_back(e + 32'd4);
            end
            exp_npc = PC + 32'd4;
          end
          if (redirect_valid) begin
            tgt = redirect_target & 32'hFFFF_FFFC;
            exp_q.delete();
            exp_q.push_back(tgt);
            exp_npc = tgt;
          end
        end
        check32("next_PC", next_PC, exp_npc);
        check32("fetch_err", 32'(fetch_err), 32'(exp_err));
      end
    end
  end

  // Wait (bounded) for a valid instruction, optionally at a given pc.
  task automatic wait_valid(input bit any_pc, input logic [31:0] pc, input int budget,
                            input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_if.instr_valid && (any_pc || bus_if.instr_pc == pc)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout waiting for instr_valid (cycle %0d)", name, cyc);
    end
  endtask

  task automatic wait_req(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_if.imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout waiting for imem_req (cycle %0d)", name, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check32({tag, "_imem_req"}, 32'(bus_if.imem_req), 32'd0);
    check32({tag, "_imem_addr"}, bus_if.imem_addr, 32'h0);
    check32({tag, "_instr_valid"}, 32'(bus_if.instr_valid), 32'd0);
    check32({tag, "_instr"}, bus_if.instr, 32'h0);
    check32({tag, "_instr_pc"}, bus_if.instr_pc, 32'h0);
    check32({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    check32({tag, "_next_PC"}, next_PC, 32'h0);
  endtask

  initial begin : driver
    bit          ok;
    int          rst_cyc;
    int          t;
    logic [31:0] ref_instr;
    logic [31:0] ref_pc;

    bus_if.instr_ready = 1'b1;

    // Reset and start-up with latency 2.
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    rst_cyc = cyc;
    req_log.delete();
    for (int i = 0; i < 40 && req_log.size() < 3; i++) step();
    if (req_log.size() < 3) begin
      n_cmp++;
      n_fail++;
      $display("FAIL startup: only %0d requests seen", req_log.size());
    end else begin
      check32("startup_first_cycle", 32'(req_log[0].c), 32'(rst_cyc + 1));
      check32("startup_addr0", req_log[0].a, 32'h0);
      check32("startup_addr1", req_log[1].a, 32'h4);
      check32("startup_addr2", req_log[2].a, 32'h8);
      check32("startup_gap01", 32'(req_log[1].c - req_log[0].c), 32'd4);
      check32("startup_gap12", 32'(req_log[2].c - req_log[1].c), 32'd4);
    end

    // Decode stall for 5 cycles in HOLD.
    bus_if.instr_ready = 1'b0;
    wait_valid(1'b1, '0, 20, "stall_enter", ok);
    if (ok) begin
      ref_instr = bus_if.instr;
      ref_pc    = bus_if.instr_pc;
      for (int i = 0; i < 5; i++) begin
        check32("stall_valid", 32'(bus_if.instr_valid), 32'd1);
        check32("stall_instr", bus_if.instr, ref_instr);
        check32("stall_instr_pc", bus_if.instr_pc, ref_pc);
        check32("stall_no_req", 32'(bus_if.imem_req), 32'd0);
        check32("stall_next_PC", next_PC, PC);
        step();
      end
      bus_if.instr_ready = 1'b1;
      #1;
      check32("stall_release_next_PC", next_PC, PC + 32'd4);
    end

    // Redirect to 0x403 while waiting; stale response two cycles later.
    mem_lat = 3;
    step();
    wait_req(20, "wait_redirect_req", ok);
    if (ok) begin
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0403;
      step();
      redirect_valid = 1'b0;
      wait_req(20, "wait_redirect_next_req", ok);
      if (ok) check32("wait_redirect_addr", bus_if.imem_addr, 32'h0000_0400);
    end
    mem_lat = 2;

    // Redirect in the same cycle as accept of 0x20.
    bus_if.instr_ready = 1'b0;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0020;
    step();
    redirect_valid = 1'b0;
    wait_valid(1'b0, 32'h20, 30, "racc_0x20", ok);
    if (ok) begin
      bus_if.instr_ready = 1'b1;
      redirect_valid     = 1'b1;
      redirect_target    = 32'h0000_0100;
      #1;
      check32("racc_next_PC", next_PC, 32'h0000_0100);
      step();
      bus_if.instr_ready = 1'b0;
      redirect_valid     = 1'b0;
      check32("racc_valid_drop", 32'(bus_if.instr_valid), 32'd0);
      wait_valid(1'b1, '0, 30, "racc_next", ok);
      if (ok) check32("racc_next_pc", bus_if.instr_pc, 32'h0000_0100);
    end

    // PC wrap at the top of the address space; low target bits ignored.
    bus_if.instr_ready = 1'b0;
    redirect_valid     = 1'b1;
    redirect_target    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    wait_valid(1'b0, 32'hFFFF_FFFC, 30, "wrap_top", ok);
    if (ok) begin
      bus_if.instr_ready = 1'b1;
      #1;
      check32("wrap_next_PC", next_PC, 32'h0);
      step();
      bus_if.instr_ready = 1'b0;
      wait_valid(1'b1, '0, 30, "wrap_next", ok);
      if (ok) check32("wrap_next_pc", bus_if.instr_pc, 32'h0);
    end

    // Randomized traffic: latency, stalls, redirects, spurious rvalid.
    mem_lat = 0;
    spur_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus_if.instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid     = ($urandom_range(0, 19) == 0);
      redirect_target    = $urandom();
      step();
    end
    redirect_valid     = 1'b0;
    spur_en            = 1'b0;
    bus_if.instr_ready = 1'b1;
    mem_lat            = 2;

    // Watchdog with MAX_WAIT=4 and a memory that never answers.
    step();
    wait_req(20, "wdog_req", ok);
    if (ok) begin
      mem_mute = 1'b1;
      t = cyc;
      repeat (4) step();
      check32("wdog_not_yet", 32'(fetch_err), 32'd0);
      check32("wdog_cycle4", 32'(cyc - t), 32'd4);
      step();
      exp_err = 1'b1;
      check32("wdog_fired", 32'(fetch_err), 32'd1);
      step();
      mem_force       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0500;
      step();
      mem_force      = 1'b0;
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check32("err_late_valid", 32'(bus_if.instr_valid), 32'd0);
        check32("err_sticky", 32'(fetch_err), 32'd1);
        check32("err_hold_PC", next_PC, PC);
        step();
      end
    end

    // Reset clears the error and restarts fetching from 0.
    reset   = 1'b1;
    exp_err = 1'b0;
    repeat (2) step();
    check_reset_values("rereset");
    mem_mute = 1'b0;
    reset    = 1'b0;
    wait_valid(1'b1, '0, 20, "restart", ok);
    if (ok) check32("restart_pc", bus_if.instr_pc, 32'h0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
